// File: rtl/pkt_drop_sequencer.sv
// pkt_drop_sequencer: per-packet lookup/decision gate with atomic forward/drop and statistics.
// Optional macro DROP_STATS_EN adds per-reason and timeout counters; otherwise those ports read 0.
module pkt_drop_sequencer #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int DROP_REASONS         = 5,
    parameter int CNT_WIDTH            = 32,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input  logic                                AXI_ACLK,
    input  logic                                AXI_RESETN,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    input  logic                                S_AXIS_TLAST,
    output logic                                S_AXIS_TREADY,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,
    output logic                                REQ_VALID,
    input  logic                                REQ_READY,
    input  logic                                DEC_VALID,
    input  logic [DROP_REASONS-1:0]             DEC_DROP,
    output logic                                DEC_READY,
    input  logic                                CNT_CLEAR,
    output logic [CNT_WIDTH-1:0]                FWD_COUNT,
    output logic [CNT_WIDTH-1:0]                DROP_COUNT,
    output logic [DROP_REASONS*CNT_WIDTH-1:0]   REASON_COUNT,
    output logic [CNT_WIDTH-1:0]                TIMEOUT_COUNT
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int BW = DW + DW / 8 + C_S_AXIS_TUSER_WIDTH + 1;
    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT_DEC, FWD, DROP} state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [BW-1:0]   skid_q [2];
    logic [1:0]      cnt_q;
    logic [CNT_WIDTH-1:0] fwd_q, drop_q;
    logic [BW-1:0]   din;
    logic s_fire, dec_fire, timeout, drop_ev, fwd_ev, push, pop, full;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic inc, input logic clr);
        return clr ? '0 : (inc && !(&c)) ? c + CNT_WIDTH'(1) : c;
    endfunction

    assign full          = cnt_q == 2'd2;
    assign S_AXIS_TREADY = (state_q == FWD && !full) || state_q == DROP;
    assign REQ_VALID     = state_q == REQ;
    assign DEC_READY     = state_q == WAIT_DEC;
    assign s_fire        = S_AXIS_TVALID && S_AXIS_TREADY;
    assign dec_fire      = state_q == WAIT_DEC && DEC_VALID;
    assign timeout       = state_q == WAIT_DEC && !DEC_VALID && TIMEOUT_CYCLES != 0 && timer_q == TW'(1);
    assign drop_ev       = (dec_fire && |DEC_DROP) || timeout;
    assign push          = state_q == FWD && s_fire;
    assign fwd_ev        = push && S_AXIS_TLAST;
    assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;
    assign din           = {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
    assign M_AXIS_TVALID = cnt_q != 2'd0;
    assign {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA} = skid_q[0];
    assign FWD_COUNT     = fwd_q;
    assign DROP_COUNT    = drop_q;

    // Packet sequencing: hold head, request lookup, await decision (or timeout), then pass or discard.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            case (state_q)
                IDLE:     if (S_AXIS_TVALID) state_q <= REQ;
                REQ:      if (REQ_READY) begin
                              state_q <= WAIT_DEC;
                              timer_q <= TW'(TIMEOUT_CYCLES);
                          end
                WAIT_DEC: begin
                              timer_q <= timer_q - TW'(1);
                              if (dec_fire) state_q <= |DEC_DROP ? DROP : FWD;
                              else if (timeout) state_q <= DROP;
                          end
                FWD:      if (fwd_ev) state_q <= IDLE;
                DROP:     if (s_fire && S_AXIS_TLAST) state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    // Two-entry output skid: entry 0 drives M_AXIS_*, entry 1 catches a beat while the sink stalls.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            cnt_q     <= '0;
            skid_q[0] <= '0;
            skid_q[1] <= '0;
        end else begin
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
            if (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) skid_q[0] <= din;
            else if (pop) skid_q[0] <= skid_q[1];
            if (push && cnt_q == 2'd1 && !pop) skid_q[1] <= din;
        end
    end

    // Forward and drop packet counters, saturating; clear beats a same-cycle increment.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            fwd_q  <= '0;
            drop_q <= '0;
        end else begin
            fwd_q  <= sat_inc(fwd_q, fwd_ev, CNT_CLEAR);
            drop_q <= sat_inc(drop_q, drop_ev, CNT_CLEAR);
        end
    end

`ifdef DROP_STATS_EN
    logic [CNT_WIDTH-1:0] reason_q [DROP_REASONS];
    logic [CNT_WIDTH-1:0] timeout_q;

    // Per-reason hit counters and decision-timeout counter.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            timeout_q <= '0;
            for (int i = 0; i < DROP_REASONS; i++) reason_q[i] <= '0;
        end else begin
            timeout_q <= sat_inc(timeout_q, timeout, CNT_CLEAR);
            for (int i = 0; i < DROP_REASONS; i++) reason_q[i] <= sat_inc(reason_q[i], dec_fire && DEC_DROP[i], CNT_CLEAR);
        end
    end

    for (genvar r = 0; r < DROP_REASONS; r++) begin : g_reason
        assign REASON_COUNT[r*CNT_WIDTH +: CNT_WIDTH] = reason_q[r];
    end
    assign TIMEOUT_COUNT = timeout_q;
`else
    assign REASON_COUNT  = '0;
    assign TIMEOUT_COUNT = '0;
`endif
endmodule

// File: doc/pkt_drop_sequencer.md
Name: pkt_drop_sequencer

Overview:
Per-packet drop controller placed between the RX-side AXI-Stream input and the output-port-lookup datapath.
- Holds each packet's head beat and issues a lookup request, then waits for the drop decision.
- Forwards or discards the whole packet atomically, so drops always fall on packet boundaries.
- Keeps forward/drop statistics.
- Output passes through a 2-entry skid buffer.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master tdata width (tstrb = /8)
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width; must equal master
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal master
- DROP_REASONS, 5, width of the decision reason vector
- CNT_WIDTH, 32, statistics counter width
- TIMEOUT_CYCLES, 255, max cycles in WAIT_DEC; 0 disables the timeout

Ports:
- AXI_ACLK  in  1  clock
- AXI_RESETN  in  1  asynchronous active-low reset
- S_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  in  per params  input stream
- S_AXIS_TREADY  out  1  input ready
- M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  out  per params  output stream
- M_AXIS_TREADY  in  1  output ready
- REQ_VALID  out  1  lookup request; engine samples S_AXIS_TDATA/TUSER while high
- REQ_READY  in  1  lookup accepted
- DEC_VALID  in  1  decision valid
- DEC_DROP  in  DROP_REASONS  reason bits; nonzero = drop
- DEC_READY  out  1  decision accepted
- CNT_CLEAR  in  1  synchronous clear of all counters
- FWD_COUNT  out  CNT_WIDTH  packets forwarded
- DROP_COUNT  out  CNT_WIDTH  packets dropped (all causes)
- REASON_COUNT  out  DROP_REASONS*CNT_WIDTH  per-reason drop hits
- TIMEOUT_COUNT  out  CNT_WIDTH  decision timeouts

Behaviour:
- Reset (asynchronous, AXI_RESETN=0):
  - FSM goes to IDLE; skid buffer is emptied.
  - All counters are cleared to 0.
  - All outputs are 0: S_AXIS_TREADY, M_AXIS_TVALID, REQ_VALID, DEC_READY.
- Reset mid-packet: remaining upstream beats after release are treated as a new packet head. Upstream is reset together with this block.
- FSM states: IDLE, REQ, WAIT_DEC, FWD, DROP.
  - IDLE: on S_AXIS_TVALID, go to REQ next cycle. S_AXIS_TREADY=0, so the head beat is held stable.
  - REQ: REQ_VALID=1. On REQ_VALID&REQ_READY, go to WAIT_DEC and load the timer.
  - WAIT_DEC: DEC_READY=1. On DEC_VALID:
    - DEC_DROP==0 goes to FWD.
    - Otherwise goes to DROP; DROP_COUNT+1 and each set reason bit's counter +1.
    - The timer decrements each cycle. On reaching 0 with no decision (TIMEOUT_CYCLES!=0), go to DROP; DROP_COUNT+1 and TIMEOUT_COUNT+1.
    - A decision arriving in the same cycle as expiry wins over the timeout.
  - FWD: S_AXIS_TREADY = skid buffer not full. Accepted beats are written to the skid buffer. The beat with TLAST accepted gives FWD_COUNT+1 and returns to IDLE.
  - DROP: S_AXIS_TREADY=1, beats discarded. TLAST accepted returns to IDLE.
- Single-beat packet (TLAST on head beat): passes through the full sequence and returns to IDLE after that one beat.
- Packet rate: at most one packet head per 3 cycles; back-to-back beats within a packet run at full rate.
- Skid buffer:
  - 2 entries, registered outputs; latency input accept to M_AXIS_TVALID = 1 cycle.
  - M_AXIS_* stay stable while TVALID&!TREADY.
  - Full means 2 entries held; simultaneous push and pop when full is not allowed (TREADY=0 when full).
  - Skid contents drain independently of FSM state.
- Counters: saturate at all-ones, no wrap. CNT_CLEAR wins over a same-cycle increment (result 0).
- Never forwards a partial packet; never blocks REQ/DEC handshakes on M_AXIS_TREADY.

Optional Feature:
DROP_STATS_EN
- Defined: REASON_COUNT and TIMEOUT_COUNT are implemented as above.
- Undefined: both ports are driven constant 0 and no per-reason or timeout counter flops exist. FWD_COUNT and DROP_COUNT are always present.

Test Plan:
- 4-beat packet, REQ_READY immediate, DEC_DROP=0 after 2 cycles, M_AXIS_TREADY=1 -> 4 beats out unchanged, first M_AXIS_TVALID 1 cycle after first accept, FWD_COUNT=1.
- 3-beat packet, DEC_DROP=5'b00100 -> M_AXIS_TVALID never 1, all 3 beats consumed, DROP_COUNT=1, reason[2] count=1 (DROP_STATS_EN).
- TIMEOUT_CYCLES=4, DEC_VALID never asserted -> DROP entered 4 cycles after REQ handshake, TIMEOUT_COUNT=1, packet discarded; next packet forwards normally.
- Forwarding 8-beat packet with M_AXIS_TREADY toggling 1/0 per cycle -> no beat lost or duplicated, TREADY low when 2 entries held, output stable while stalled.
- Single-beat packet followed immediately by a 2-beat packet, both DEC_DROP=0 -> both forwarded in order, FWD_COUNT=2, REQ_VALID asserted once per packet.
- AXI_RESETN asserted in the middle of FWD -> all outputs 0 immediately, counters 0, FSM in IDLE; CNT_CLEAR with a same-cycle drop -> DROP_COUNT=0.
